// File: rtl/sprite_position_ctrl.sv
// sprite_position_ctrl: debounced four-button control of an on-screen-clamped sprite position
module sprite_position_ctrl #(
  parameter int H_VISIBLE_AREA = 640,
  parameter int V_VISIBLE_AREA = 480,
  parameter int TILE_SIZE      = 16,
  parameter int STEP           = 16,
  parameter int INIT_X         = 0,
  parameter int INIT_Y         = 0,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int REPEAT_DELAY   = 12500000,
  parameter int REPEAT_PERIOD  = 2500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Up,
  input  logic       i_Down,
  input  logic       i_Left,
  input  logic       i_Right,
  output logic [9:0] o_X_Position,
  output logic [9:0] o_Y_Position,
  output logic       o_Step_Pulse
);
  localparam int DW = $clog2(DEBOUNCE_LIMIT) + 1;
  localparam int RM = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RM) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_LIMIT - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [10:0] X_MAX  = 11'(H_VISIBLE_AREA - TILE_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(V_VISIBLE_AREA - TILE_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

  state_t state_q, state_d;
  dir_t dir_q, dir_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [3:0] raw, sync1_q, sync2_q, db_q, db_d;
  logic [DW-1:0] dbc_q [4];
  logic [DW-1:0] dbc_d [4];
  logic [9:0] x_q, x_d, y_q, y_d, left_x, right_x, up_y, down_y;
  logic [10:0] x_sum, y_sum;
  logic step, pulse_q, pulse_d;

  assign raw = {i_Right, i_Left, i_Down, i_Up};
  assign o_X_Position = x_q;
  assign o_Y_Position = y_q;
  assign o_Step_Pulse = pulse_q;

  // Two-flop synchroniser for the asynchronous raw buttons
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-button debounce: accept a change only after it has held for DEBOUNCE_LIMIT clocks
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 4; i++) begin
      dbc_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (dbc_q[i] == DB_LAST) db_d[i] = sync2_q[i];
        else dbc_d[i] = dbc_q[i] + 1'b1;
      end
    end
  end

  // Debounced state and counters
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      db_q  <= '0;
      dbc_q <= '{default: '0};
    end else begin
      db_q  <= db_d;
      dbc_q <= dbc_d;
    end
  end

  // Movement FSM with repeat timing, plus clamped step arithmetic on the selected axis
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rcnt_d  = rcnt_q;
    step    = 1'b0;
    case (state_q)
      IDLE: if (|db_q) begin
        state_d = DELAY;
        dir_d   = db_q[0] ? UP : db_q[1] ? DOWN : db_q[2] ? LEFT : RIGHT;
        rcnt_d  = '0;
        step    = 1'b1;
      end
      DELAY, REPEAT: if (!db_q[dir_q]) begin
        state_d = IDLE;
        rcnt_d  = '0;
      end else if (rcnt_q == (state_q == DELAY ? RD_LAST : RP_LAST)) begin
        state_d = REPEAT;
        rcnt_d  = '0;
        step    = 1'b1;
      end else rcnt_d = rcnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
    x_sum   = {1'b0, x_q} + STEP_W;
    y_sum   = {1'b0, y_q} + STEP_W;
    left_x  = {1'b0, x_q} < STEP_W ? 10'd0 : x_q - STEP_W[9:0];
    up_y    = {1'b0, y_q} < STEP_W ? 10'd0 : y_q - STEP_W[9:0];
    right_x = x_sum > X_MAX ? X_MAX[9:0] : x_sum[9:0];
    down_y  = y_sum > Y_MAX ? Y_MAX[9:0] : y_sum[9:0];
    x_d     = !step ? x_q : dir_d == LEFT ? left_x : dir_d == RIGHT ? right_x : x_q;
    y_d     = !step ? y_q : dir_d == UP ? up_y : dir_d == DOWN ? down_y : y_q;
    pulse_d = (x_d != x_q) || (y_d != y_q);
  end

  // FSM, repeat counter and position registers
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      dir_q   <= UP;
      rcnt_q  <= '0;
      x_q     <= 10'(INIT_X);
      y_q     <= 10'(INIT_Y);
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rcnt_q  <= rcnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pulse_q <= pulse_d;
    end
  end
endmodule

// File: tb/tb_sprite_position_ctrl.sv
// tb_sprite_position_ctrl: table-driven and cycle-exact checks of sprite_position_ctrl
module tb_sprite_position_ctrl;
  typedef struct {
    string name;
    int dut;
    logic [3:0] btn;
    int hold;
    int ex;
    int ey;
    int ep;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] b [4];
  logic [9:0] xo [4];
  logic [9:0] yo [4];
  logic po [4];
  int pc [4];
  int exp_q [$];
  int n_chk = 0;
  int n_fail = 0;
  int ix [4] = '{0, 608, 5, 100};
  int iy [4] = '{0, 0, 0, 100};
  vec_t vt [13];

  always #5 clk = ~clk;

  sprite_position_ctrl #(.INIT_X(0), .INIT_Y(0), .DEBOUNCE_LIMIT(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .STEP(16)) u_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Up(b[0][0]), .i_Down(b[0][1]), .i_Left(b[0][2]), .i_Right(b[0][3]),
    .o_X_Position(xo[0]), .o_Y_Position(yo[0]), .o_Step_Pulse(po[0]));
  sprite_position_ctrl #(.INIT_X(608), .INIT_Y(0), .DEBOUNCE_LIMIT(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .STEP(16)) u_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Up(b[1][0]), .i_Down(b[1][1]), .i_Left(b[1][2]), .i_Right(b[1][3]),
    .o_X_Position(xo[1]), .o_Y_Position(yo[1]), .o_Step_Pulse(po[1]));
  sprite_position_ctrl #(.INIT_X(5), .INIT_Y(0), .DEBOUNCE_LIMIT(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .STEP(16)) u_c (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Up(b[2][0]), .i_Down(b[2][1]), .i_Left(b[2][2]), .i_Right(b[2][3]),
    .o_X_Position(xo[2]), .o_Y_Position(yo[2]), .o_Step_Pulse(po[2]));
  sprite_position_ctrl #(.INIT_X(100), .INIT_Y(100), .DEBOUNCE_LIMIT(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .STEP(16)) u_d (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Up(b[3][0]), .i_Down(b[3][1]), .i_Left(b[3][2]), .i_Right(b[3][3]),
    .o_X_Position(xo[3]), .o_Y_Position(yo[3]), .o_Step_Pulse(po[3]));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) if (po[k]) pc[k]++;
    end
  endtask

  task automatic set_vec(input int i, input string name, input int dut, input logic [3:0] btn,
                         input int hold, input int ex, input int ey, input int ep);
    vt[i].name = name; vt[i].dut = dut; vt[i].btn = btn; vt[i].hold = hold;
    vt[i].ex = ex; vt[i].ey = ey; vt[i].ep = ep;
  endtask

  initial begin
    // btn bits: [0]=Up [1]=Down [2]=Left [3]=Right; dut 0:(0,0) 1:(608,0) 2:(5,0) 3:(100,100)
    set_vec(0,  "glitch3",      0, 4'b1000, 3, 0,   0,   0);
    set_vec(1,  "right_step",   0, 4'b1000, 8, 16,  0,   1);
    set_vec(2,  "clamp_right",  1, 4'b1000, 8, 624, 0,   1);
    set_vec(3,  "clamp_nochg",  1, 4'b1000, 8, 624, 0,   0);
    set_vec(4,  "clamp_left5",  2, 4'b0100, 8, 0,   0,   1);
    set_vec(5,  "up_over_left", 3, 4'b0101, 9, 100, 84,  1);
    set_vec(6,  "left_to_0",    0, 4'b0100, 8, 0,   0,   1);
    set_vec(7,  "left_at_0",    0, 4'b0100, 8, 0,   0,   0);
    set_vec(8,  "up_at_0",      0, 4'b0001, 8, 0,   0,   0);
    set_vec(9,  "down_over_rt", 3, 4'b1010, 8, 100, 100, 1);
    set_vec(10, "hold_exact4",  1, 4'b0010, 4, 624, 16,  1);
    set_vec(11, "glitch_up3",   1, 4'b0001, 3, 624, 16,  0);
    set_vec(12, "up_over_down", 3, 4'b0011, 8, 100, 84,  1);
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) b[k] = 4'b0;
    tick(2);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_x%0d", k), int'(xo[k]), ix[k]);
      chk($sformatf("reset_y%0d", k), int'(yo[k]), iy[k]);
      chk($sformatf("reset_p%0d", k), int'(po[k]), 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      pc = '{default: 0};
      exp_q.push_back(vt[i].ex);
      exp_q.push_back(vt[i].ey);
      exp_q.push_back(vt[i].ep);
      b[vt[i].dut] = vt[i].btn;
      tick(vt[i].hold);
      b[vt[i].dut] = 4'b0;
      tick(20);
      chk({vt[i].name, ".x"}, int'(xo[vt[i].dut]), exp_q.pop_front());
      chk({vt[i].name, ".y"}, int'(yo[vt[i].dut]), exp_q.pop_front());
      chk({vt[i].name, ".pulses"}, pc[vt[i].dut], exp_q.pop_front());
    end
    // exact press latency and single-clock pulse on dut 0 at (0,0)
    b[0] = 4'b1000;
    tick(6);
    chk("lat_before_x", int'(xo[0]), 0);
    tick(1);
    chk("lat_at_x", int'(xo[0]), 16);
    chk("lat_at_p", int'(po[0]), 1);
    tick(1);
    chk("lat_after_p", int'(po[0]), 0);
    b[0] = 4'b0;
    tick(20);
    chk("lat_final_x", int'(xo[0]), 16);
    // held Down for 40 clocks: steps at 7, then 17+3k, release detected at 47 suppresses that step
    for (int c = 1; c <= 60; c++) begin
      int n;
      bit s;
      s = (c == 7) || (c >= 17 && c < 47 && (c - 17) % 3 == 0);
      n = (c >= 7) ? 1 : 0;
      for (int t = 17; t < 47; t += 3) if (t <= c) n++;
      exp_q.push_back(16 * n);
      exp_q.push_back(int'(s));
    end
    b[0] = 4'b0010;
    for (int c = 1; c <= 60; c++) begin
      tick(1);
      if (c == 40) b[0] = 4'b0;
      chk($sformatf("repeat_y_c%0d", c), int'(yo[0]), exp_q.pop_front());
      chk($sformatf("repeat_p_c%0d", c), int'(po[0]), exp_q.pop_front());
    end
    // dut 3 at (100,84): Up latched over Left; Left only acts once Up release returns to IDLE
    for (int c = 1; c <= 30; c++) begin
      exp_q.push_back(c >= 17 ? 84 : 100);
      exp_q.push_back(c >= 7 ? 68 : 84);
    end
    b[3] = 4'b0101;
    for (int c = 1; c <= 30; c++) begin
      tick(1);
      if (c == 9) b[3] = 4'b0100;
      if (c == 12) b[3] = 4'b0;
      chk($sformatf("latch_x_c%0d", c), int'(xo[3]), exp_q.pop_front());
      chk($sformatf("latch_y_c%0d", c), int'(yo[3]), exp_q.pop_front());
    end
    // reset in the middle of a Right repeat on dut 0 at (16,176), button held throughout
    b[0] = 4'b1000;
    tick(21);
    chk("mid_pre_x", int'(xo[0]), 64);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_x", int'(xo[0]), 0);
    chk("mid_rst_y", int'(yo[0]), 0);
    chk("mid_rst_p", int'(po[0]), 0);
    tick(1);
    rst_n = 1'b1;
    tick(6);
    chk("mid_rel6_x", int'(xo[0]), 0);
    tick(1);
    chk("mid_rel7_x", int'(xo[0]), 16);
    chk("mid_rel7_p", int'(po[0]), 1);
    b[0] = 4'b0;
    tick(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
